seven_seg_scan_driver: RTL and testbench
========================================

// Module: seven_seg_scan_driver
//
// PURPOSE
// - Consumer of overflowClockDivider output: uses dividedClk as scan strobe to time-multiplex
//   NUM_DIGITS hex digits onto the Nexys4 DDR common-anode 7-segment display.
// - Blanks all anodes for BLANK_CYCLES clk cycles between digits to suppress ghosting.
// - Snapshots value/dp/mask once per frame so a mid-frame update never tears.
//
// PARAMETERS
// - NUM_DIGITS    8   digits scanned, 1..8; index width = clog2(NUM_DIGITS), min 1
// - BLANK_CYCLES  4   clk cycles all anodes off after each digit advance, >=1
//
// PORTS
// - clk         in   1               system clock, rising edge
// - reset       in   1               asynchronous, active-high
// - enable      in   1               1 = scanning, 0 = display dark
// - dividedClk  in   1               strobe from overflowClockDivider, same clk domain
// - value       in   4*NUM_DIGITS    hex nibbles, digit 0 = bits [3:0]
// - dpIn        in   NUM_DIGITS      decimal point per digit, 1 = lit
// - digitMask   in   NUM_DIGITS      1 = digit shown, 0 = slot kept but dark
// - anode       out  NUM_DIGITS      active-low digit select
// - seg         out  7               active-low cathodes {g,f,e,d,c,b,a}
// - dp          out  1               active-low decimal point
//
// BEHAVIOUR
// - Reset (async): anode all 1, seg 7'h7F, dp 1, FSM IDLE, idx 0, prevTick 0, snapshot 0.
// - All outputs registered. Edge detect: advance = dividedClk & ~prevTick (prevTick registered).
// - FSM IDLE: outputs dark. enable=1 -> BLANK with idx 0, blank counter loaded, snapshot taken.
// - FSM BLANK: outputs dark; counter decrements each clk; at 0 -> DRIVE next cycle.
// - FSM DRIVE: anode[idx]=0 (if mask bit set in snapshot), seg = hex decode of nibble idx,
//   dp = ~dp bit idx. Remains until advance.
// - advance in DRIVE or BLANK: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1, reload counter, -> BLANK.
//   Edge during BLANK restarts blank interval (no queuing of strobes).
// - Wrap to idx 0 (and IDLE->BLANK entry): value/dpIn/digitMask captured into snapshot;
//   otherwise inputs ignored. Display latency of a new value <= one full frame.
// - Latency: advance seen at clk edge n -> anode all 1 at n+1 -> new digit lit at n+1+BLANK_CYCLES.
// - enable deasserted in any state: next cycle IDLE, outputs dark, idx 0; advance ignored.
// - dividedClk held high: single advance only (edge, not level).
// - Hex decode: 0..F standard (A,b,C,d,E,F); seg encoding fixed active-low.
// - digitMask bit 0: slot time consumed, anode stays 1 -- uniform brightness across digits.
//
// CONFIGURATION
// - Macro LEADING_ZERO_BLANK_EN defined: at snapshot, digits above the most significant
//   nonzero nibble are forced masked (dark, dp also dark); digit 0 always shown if its
//   mask bit is set. value==0 shows single "0".
// - Macro absent: every masked-in digit displayed, including leading zeros.
//
// TESTING
// - Reset mid-DRIVE (reset pulse, async) -> anode=8'hFF, seg=7'h7F, dp=1 same timestep, no clk needed.
// - enable=1, value=32'h89AB_CDEF, mask=8'hFF, 8 strobes -> digits 0..7 show F,E,D,C,B,A,9,8
//   (seg=7'h0E for F), anode=8'hFE..8'h7F, each preceded by exactly 4 dark cycles.
// - value changed 32'h0->32'h1111_1111 during digit 3 -> digits 4..7 still show 0; after wrap all 1.
// - dividedClk held high 20 cycles -> exactly one idx advance; strobe during BLANK -> blank restarts.
// - enable dropped in DRIVE digit 5 -> dark next cycle; re-enable -> BLANK then digit 0.
// - value=32'h0000_0042, mask=8'hFF: with LEADING_ZERO_BLANK_EN only digits 0,1 lit; without, all 8.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// Purpose: time-multiplexes NUM_DIGITS hex digits onto a common-anode 7-segment display, scan strobe = dividedClk edge.
// Latency: strobe edge at clk n -> all anodes dark at n+1 -> next digit lit at n+1+BLANK_CYCLES; outputs registered.
// Backpressure: none; strobes arriving during the blank gap restart it (no queuing), enable=0 darkens on the next clk.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero digits at each frame snapshot.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    dividedClk,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dpIn,
    input  logic [NUM_DIGITS-1:0]   digitMask,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    // Counter runs BLANK_CYCLES-1 down to 0, giving exactly BLANK_CYCLES dark cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scanState_t;

    scanState_t              state;
    scanState_t              stateNext;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idxNext;
    logic [CNT_W-1:0]        blankCnt;
    logic [CNT_W-1:0]        blankCntNext;
    logic                    prevTick;
    logic                    advance;
    logic                    takeSnap;

    logic [4*NUM_DIGITS-1:0] valueSnap;
    logic [NUM_DIGITS-1:0]   dpSnap;
    logic [NUM_DIGITS-1:0]   maskSnap;
    logic [NUM_DIGITS-1:0]   maskCapture;

    logic [3:0]              curNibble;
    logic                    curShown;

    // Active-low {g,f,e,d,c,b,a} encoding of one hex nibble.
    function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Rising-edge detect so a strobe held high advances exactly once.
    assign advance = dividedClk & ~prevTick;

    // Strobe history register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prevTick <= 1'b0;
        end else begin
            prevTick <= dividedClk;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS:0]   nzAtOrAbove;
    logic [NUM_DIGITS-1:0] lzKeep;

    // A digit is kept when it or any higher nibble is nonzero; digit 0 is always kept so zero reads "0".
    always_comb begin
        nzAtOrAbove             = '0;
        lzKeep                  = '0;
        nzAtOrAbove[NUM_DIGITS] = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nzAtOrAbove[i] = nzAtOrAbove[i+1] | (value[4*i +: 4] != 4'h0);
            lzKeep[i]      = nzAtOrAbove[i] | (i == 0);
        end
        maskCapture = digitMask & lzKeep;
    end
`else
    assign maskCapture = digitMask;
`endif

    // Scan FSM next-state: IDLE -> BLANK -> DRIVE, any strobe forces a fresh BLANK gap on the next digit.
    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        blankCntNext = blankCnt;
        takeSnap     = 1'b0;
        if (!enable) begin
            stateNext = IDLE;
            idxNext   = '0;
        end else begin
            case (state)
                IDLE: begin
                    stateNext    = BLANK;
                    idxNext      = '0;
                    blankCntNext = CNT_LOAD;
                    takeSnap     = 1'b1;
                end
                BLANK, DRIVE: begin
                    if (advance) begin
                        stateNext    = BLANK;
                        blankCntNext = CNT_LOAD;
                        if (idx == LAST_IDX) begin
                            // Frame boundary: the only point new inputs are taken, so frames never tear.
                            idxNext  = '0;
                            takeSnap = 1'b1;
                        end else begin
                            idxNext = idx + IDX_W'(1);
                        end
                    end else if (state == BLANK) begin
                        if (blankCnt == '0) begin
                            stateNext = DRIVE;
                        end else begin
                            blankCntNext = blankCnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    stateNext = IDLE;
                    idxNext   = '0;
                end
            endcase
        end
    end

    // Scan FSM state, digit index and blank counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            blankCnt <= '0;
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            blankCnt <= blankCntNext;
        end
    end

    // Per-frame snapshot of the display contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valueSnap <= '0;
            dpSnap    <= '0;
            maskSnap  <= '0;
        end else if (takeSnap) begin
            valueSnap <= value;
            dpSnap    <= dpIn;
            maskSnap  <= maskCapture;
        end
    end

    assign curNibble = valueSnap[{idx, 2'b00} +: 4];
    assign curShown  = maskSnap[idx];

    // Registered outputs: lit only while driving a shown digit; a masked slot still takes its time but stays dark.
    // Gating with enable makes the display go dark on the very clk that sees enable drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode <= '1;
            seg   <= 7'h7F;
            dp    <= 1'b1;
        end else begin
            anode <= '1;
            seg   <= 7'h7F;
            dp    <= 1'b1;
            if (enable && (state == DRIVE) && curShown) begin
                anode <= ~(NUM_DIGITS'(1) << idx);
                seg   <= hexToSeg(curNibble);
                dp    <= ~dpSnap[idx];
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Purpose: directed self-checking bench for seven_seg_scan_driver (8 digits, 4 blank cycles).
// Latency: checks strobe -> dark -> lit timing and frame-snapshot behaviour against hand-computed values.
// Backpressure: n/a; all waits are bounded by cycle counts.
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        dividedClk;
    logic [31:0] value;
    logic [7:0]  dpIn;
    logic [7:0]  digitMask;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        dp;

    int testsRun    = 0;
    int testsFailed = 0;
    int dark;
    int litCount;

    // Active-low segment codes for 0..F, written out by hand.
    logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    // Nibbles of 32'h89AB_CDEF, digit 0 first.
    logic [3:0] frameNib [8] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};

    seven_seg_scan_driver #(
        .NUM_DIGITS   (8),
        .BLANK_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dividedClk (dividedClk),
        .value      (value),
        .dpIn       (dpIn),
        .digitMask  (digitMask),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] anodeFor(input int k);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << k);
    endfunction

    // Count dark samples until some digit lights, bounded at 20 cycles.
    task automatic countDark(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (anode !== 8'hFF) break;
            n++;
        end
    endtask

    // One-cycle strobe, then count the dark gap before the next digit.
    task automatic strobeCountDark(output int n);
        dividedClk = 1'b1;
        step();
        dividedClk = 1'b0;
        countDark(n);
    endtask

    // One-cycle strobe, then wait the fixed gap so masked slots can be checked too.
    task automatic strobeFixed();
        dividedClk = 1'b1;
        step();
        dividedClk = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        dividedClk = 1'b0;
        value      = 32'h0;
        dpIn       = 8'h0;
        digitMask  = 8'hFF;
        #1;
        checkEq("reset_anode", anode, 8'hFF);
        checkEq("reset_seg", seg, 7'h7F);
        checkEq("reset_dp", dp, 1'b1);
        repeat (2) step();
        reset = 1'b0;
        step();
        checkEq("idle_dark", anode, 8'hFF);

        // Full frame 89AB_CDEF, dp on digits 0 and 2.
        value  = 32'h89AB_CDEF;
        dpIn   = 8'h05;
        enable = 1'b1;
        countDark(dark);
        checkEq("enter_dark", dark, 5);
        checkEq("d0_anode", anode, 8'hFE);
        checkEq("d0_seg", seg, 7'h0E);
        checkEq("d0_dp", dp, 1'b0);
        for (int k = 1; k < 8; k++) begin
            strobeCountDark(dark);
            checkEq($sformatf("d%0d_dark", k), dark, 4);
            checkEq($sformatf("d%0d_anode", k), anode, anodeFor(k));
            checkEq($sformatf("d%0d_seg", k), seg, segTab[frameNib[k]]);
            checkEq($sformatf("d%0d_dp", k), dp, (k == 2) ? 1'b0 : 1'b1);
        end

        // Mid-frame update must not tear.
        value = 32'h0;
        strobeCountDark(dark);
        checkEq("zero_d0_seg", seg, 7'h40);
        strobeCountDark(dark);
        strobeCountDark(dark);
        strobeCountDark(dark);
        checkEq("zero_d3_anode", anode, 8'hF7);
        value = 32'h1111_1111;
        for (int k = 4; k < 8; k++) begin
            strobeCountDark(dark);
            checkEq($sformatf("tear_d%0d_seg", k), seg, 7'h40);
        end
        strobeCountDark(dark);
        checkEq("wrap_d0_seg", seg, 7'h79);
        checkEq("wrap_d0_anode", anode, 8'hFE);
        strobeCountDark(dark);
        checkEq("wrap_d1_seg", seg, 7'h79);

        // Strobe held high for 20 cycles: one advance only.
        dividedClk = 1'b1;
        repeat (20) step();
        dividedClk = 1'b0;
        step();
        checkEq("held_anode", anode, 8'hFB);

        // Second strobe inside the blank gap restarts the gap and advances again.
        dividedClk = 1'b1;
        step();
        dividedClk = 1'b0;
        step();
        step();
        checkEq("inblank_dark", anode, 8'hFF);
        dividedClk = 1'b1;
        step();
        dividedClk = 1'b0;
        countDark(dark);
        checkEq("restart_dark", dark, 4);
        checkEq("restart_anode", anode, 8'hEF);

        // Drop enable while driving digit 5.
        strobeCountDark(dark);
        checkEq("d5_anode", anode, 8'hDF);
        enable = 1'b0;
        step();
        checkEq("disable_anode", anode, 8'hFF);
        checkEq("disable_seg", seg, 7'h7F);
        checkEq("disable_dp", dp, 1'b1);
        dividedClk = 1'b1;
        step();
        dividedClk = 1'b0;
        repeat (3) step();
        checkEq("disable_strobe_dark", anode, 8'hFF);
        enable = 1'b1;
        countDark(dark);
        checkEq("reenable_dark", dark, 5);
        checkEq("reenable_anode", anode, 8'hFE);
        checkEq("reenable_seg", seg, 7'h79);

        // Asynchronous reset while a digit is lit.
        #2;
        reset = 1'b1;
        #1;
        checkEq("async_rst_anode", anode, 8'hFF);
        checkEq("async_rst_seg", seg, 7'h7F);
        checkEq("async_rst_dp", dp, 1'b1);

        // Leading-zero behaviour on 0x42.
        value     = 32'h0000_0042;
        dpIn      = 8'h00;
        digitMask = 8'hFF;
        #1;
        reset = 1'b0;
        repeat (6) step();
        checkEq("lz_d0_anode", anode, 8'hFE);
        checkEq("lz_d0_seg", seg, 7'h24);
        litCount = 1;
        for (int k = 1; k < 8; k++) begin
            strobeFixed();
            if (anode !== 8'hFF) litCount++;
`ifdef LEADING_ZERO_BLANK_EN
            checkEq($sformatf("lz_d%0d_anode", k), anode, (k > 1) ? 8'hFF : anodeFor(k));
`else
            checkEq($sformatf("lz_d%0d_anode", k), anode, anodeFor(k));
`endif
            if (k == 1) checkEq("lz_d1_seg", seg, 7'h19);
        end
`ifdef LEADING_ZERO_BLANK_EN
        checkEq("lz_lit_count", litCount, 2);
`else
        checkEq("lz_lit_count", litCount, 8);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
